// File: rtl/nibble_serial_tx_pkg.sv
// Shared types for the nibble serial link, used by both transmit and receive ends.
package serial_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;
   localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/nibble_serial_tx_if.sv
// Parallel-in handshake plus serial-out link of the transmitter.
interface nibble_serial_tx_if import serial_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
   logic [WIDTH-1:0] d;
   logic             d_valid;
   logic             d_ready;
   logic             sdata;
   logic             sframe;
   logic             sfirst;
   logic             slast;
   logic             busy;

   modport master (output d, d_valid, input d_ready, sdata, sframe, sfirst, slast, busy);
   modport slave  (input d, d_valid, output d_ready, sdata, sframe, sfirst, slast, busy);
endinterface

// File: rtl/nibble_serial_tx_hold_buf.sv
// One-entry holding buffer; a write and a read in the same cycle leave it full with the new word.
module tx_hold_buf import serial_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (rd_en) full_d = 1'b0;
      if (wr_en) begin
         full_d = 1'b1;
         data_d = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign rd_data = data_q;
   assign full    = full_q;
endmodule

// File: rtl/nibble_serial_tx.sv
// Parallel-to-serial transmitter: MSB-first shifter with framing strobes and inter-word gap.
module nibble_serial_tx import serial_pkg::*; #(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int GAP_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   nibble_serial_tx_if.slave   bus
);
   localparam int              CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [3:0]       gap_q, gap_d;
   logic             buf_full, buf_wr, buf_rd;
   logic [WIDTH-1:0] buf_data;
   logic             xfer, next_word;

   // d_ready depends only on registered state and reset, never on d_valid.
   assign bus.d_ready = !buf_full && !reset;
   assign xfer        = bus.d_valid && bus.d_ready;

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      next_word = 1'b0;
      buf_rd    = 1'b0;
      buf_wr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               sh_d    = bus.d;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               if (GAP_CYCLES > 0) begin
                  state_d = GAP;
                  gap_d   = 4'd0;
               end else begin
                  next_word = 1'b1;
               end
            end else begin
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + CW'(1);
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) next_word = 1'b1;
            else                   gap_d     = gap_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // A queued word always wins over a word arriving in the same cycle.
      if (next_word) begin
         cnt_d = '0;
         if (buf_full) begin
            sh_d    = buf_data;
            state_d = SHIFT;
            buf_rd  = 1'b1;
         end else if (xfer) begin
            sh_d    = bus.d;
            state_d = SHIFT;
         end else begin
            state_d = IDLE;
         end
      end

      buf_wr = xfer && (state_q != IDLE) && !(next_word && !buf_full);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         gap_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   tx_hold_buf #(.WIDTH(WIDTH)) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr),
      .wr_data (bus.d),
      .rd_en   (buf_rd),
      .rd_data (buf_data),
      .full    (buf_full)
   );

   assign bus.sframe = (state_q == SHIFT);
   assign bus.sdata  = bus.sframe && sh_q[WIDTH-1];
   assign bus.sfirst = bus.sframe && (cnt_q == '0);
   assign bus.slast  = bus.sframe && (cnt_q == CNT_LAST);
   assign bus.busy   = (state_q != IDLE) || buf_full;
endmodule
